sram_1rw1r_ctrl: RTL and testbench

Controller that fronts one dual-port OpenRAM macro (1 read/write port, 1 read-only port, 256 x 32, byte write mask). It turns two valid/ready request channels into the macro's active-low chip-select and write-enable timing. It captures read data into per-port response buffers with backpressure. After every reset it zero-fills the array before accepting traffic. It sits between the SoC bus adapters and the macro; the macro's clk0 and clk1 are both tied to clk_i.

---
 rtl/sram_1rw1r_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_sram_1rw1r_ctrl.sv | 486 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1rw1r_ctrl.sv
// sram_1rw1r_ctrl: valid/ready front end for a 1RW+1R OpenRAM macro.
// Zero-fills the array after reset, then serves two request channels.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   req0_* / rsp0_*         port-0 read/write request, read response
//   req1_* / rsp1_*         port-1 read request, read response
//   csb0_o..din0_o, dout0_i macro port 0 (RW) pins
//   csb1_o, addr1_o, dout1_i macro port 1 (R) pins
//   init_done_o             high once the zero-fill has finished

module sram_1rw1r_rsp_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wp_q;
  logic [PW-1:0]         rp_q;
  logic [CW-1:0]         cnt_q;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[rp_q];

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wp_q] <= push_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wp_q <= ptr_inc(wp_q);
      if (pop_i)  rp_q <= ptr_inc(rp_q);
      unique case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

module sram_1rw1r_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic                  req0_we_i,
  input  logic [NUM_WMASKS-1:0] req0_wmask_i,
  input  logic [ADDR_WIDTH-1:0] req0_addr_i,
  input  logic [DATA_WIDTH-1:0] req0_wdata_i,
  output logic                  rsp0_valid_o,
  input  logic                  rsp0_ready_i,
  output logic [DATA_WIDTH-1:0] rsp0_rdata_o,
  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic [ADDR_WIDTH-1:0] req1_addr_i,
  output logic                  rsp1_valid_o,
  input  logic                  rsp1_ready_i,
  output logic [DATA_WIDTH-1:0] rsp1_rdata_o,
  output logic                  csb0_o,
  output logic                  web0_o,
  output logic [NUM_WMASKS-1:0] wmask0_o,
  output logic [ADDR_WIDTH-1:0] addr0_o,
  output logic [DATA_WIDTH-1:0] din0_o,
  input  logic [DATA_WIDTH-1:0] dout0_i,
  output logic                  csb1_o,
  output logic [ADDR_WIDTH-1:0] addr1_o,
  input  logic [DATA_WIDTH-1:0] dout1_i,
  output logic                  init_done_o
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_INIT,
    ST_IDLE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic [CW-1:0]         used0_q, used1_q;
  logic                  pend0_q, pend1_q;

  logic idle, init;
  logic pop0, pop1;
  logic acc0, acc1, rd0, wr0;
  logic hazard;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_RESET;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    unique case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == '1) state_d = ST_IDLE;
      end
      ST_IDLE: ;
      default: state_d = ST_RESET;
    endcase
  end

  assign idle        = (state_q == ST_IDLE);
  assign init        = (state_q == ST_INIT);
  assign init_done_o = idle;

  assign pop0 = rsp0_valid_o & rsp0_ready_i;
  assign pop1 = rsp1_valid_o & rsp1_ready_i;

  // A pop in the same cycle frees a credit, so a full buffer can
  // still accept while draining.
  assign req0_ready_o = idle & ((used0_q < DEPTH_C) | pop0);
  assign acc0         = req0_valid_i & req0_ready_o;
  assign rd0          = acc0 & ~req0_we_i;
  assign wr0          = acc0 & req0_we_i;

  // Same-address write/read in one macro cycle is a race; hold port 1
  // back a cycle so it sees the new data.
  assign hazard       = wr0 & (req0_addr_i == req1_addr_i);
  assign req1_ready_o = idle & ((used1_q < DEPTH_C) | pop1) & ~hazard;
  assign acc1         = req1_valid_i & req1_ready_o;

  always_comb begin
    csb0_o   = 1'b1;
    web0_o   = 1'b1;
    wmask0_o = '0;
    addr0_o  = '0;
    din0_o   = '0;
    csb1_o   = 1'b1;
    addr1_o  = '0;
    if (init) begin
      csb0_o   = 1'b0;
      web0_o   = 1'b0;
      wmask0_o = '1;
      addr0_o  = init_cnt_q;
    end else if (acc0) begin
      csb0_o   = 1'b0;
      web0_o   = ~req0_we_i;
      wmask0_o = req0_wmask_i;
      addr0_o  = req0_addr_i;
      din0_o   = req0_wdata_i;
    end
    if (acc1) begin
      csb1_o  = 1'b0;
      addr1_o = req1_addr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      used0_q <= '0;
      used1_q <= '0;
      pend0_q <= 1'b0;
      pend1_q <= 1'b0;
    end else begin
      pend0_q <= rd0;
      pend1_q <= acc1;
      unique case ({rd0, pop0})
        2'b10:   used0_q <= used0_q + 1'b1;
        2'b01:   used0_q <= used0_q - 1'b1;
        default: ;
      endcase
      unique case ({acc1, pop1})
        2'b10:   used1_q <= used1_q + 1'b1;
        2'b01:   used1_q <= used1_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Macro data is valid the cycle after issue; capture it then.
  sram_1rw1r_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RSP_DEPTH)
  ) u_rsp0 (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (pend0_q),
    .push_data_i (dout0_i),
    .pop_i       (pop0),
    .valid_o     (rsp0_valid_o),
    .data_o      (rsp0_rdata_o)
  );

  sram_1rw1r_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RSP_DEPTH)
  ) u_rsp1 (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (pend1_q),
    .push_data_i (dout1_i),
    .pop_i       (pop1),
    .valid_o     (rsp1_valid_o),
    .data_o      (rsp1_rdata_o)
  );
endmodule

// File: tb/tb_sram_1rw1r_ctrl.sv
// tb_sram_1rw1r_ctrl: self-checking bench for sram_1rw1r_ctrl.
// Behavioural macro plus reference memory and response queues.

module tb_sram_1rw1r_ctrl;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NW = 4;
  localparam int RD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req0_valid, req0_we;
  logic [NW-1:0] req0_wmask;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          rsp0_ready;
  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic          rsp1_ready;

  logic          req0_ready, req1_ready;
  logic          rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic          csb0, web0, csb1, init_done;
  logic [NW-1:0] wmask0;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout0 = '0;
  logic [DW-1:0] dout1 = '0;

  sram_1rw1r_ctrl #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW),
    .NUM_WMASKS (NW), .RSP_DEPTH (RD)
  ) dut (
    .clk_i (clk), .rst_i (rst),
    .req0_valid_i (req0_valid), .req0_ready_o (req0_ready),
    .req0_we_i (req0_we), .req0_wmask_i (req0_wmask),
    .req0_addr_i (req0_addr), .req0_wdata_i (req0_wdata),
    .rsp0_valid_o (rsp0_valid), .rsp0_ready_i (rsp0_ready),
    .rsp0_rdata_o (rsp0_rdata),
    .req1_valid_i (req1_valid), .req1_ready_o (req1_ready),
    .req1_addr_i (req1_addr),
    .rsp1_valid_o (rsp1_valid), .rsp1_ready_i (rsp1_ready),
    .rsp1_rdata_o (rsp1_rdata),
    .csb0_o (csb0), .web0_o (web0), .wmask0_o (wmask0),
    .addr0_o (addr0), .din0_o (din0), .dout0_i (dout0),
    .csb1_o (csb1), .addr1_o (addr1), .dout1_i (dout1),
    .init_done_o (init_done)
  );

  // Macro model: reads see the array before this edge's write.
  logic [DW-1:0] mac_mem [256];
  logic          scramble = 1'b0;
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < 256; i++) mac_mem[i] <= $urandom;
    end else begin
      if (!csb1) dout1 <= mac_mem[addr1];
      if (!csb0 && web0) dout0 <= mac_mem[addr0];
      if (!csb0 && !web0)
        for (int b = 0; b < NW; b++)
          if (wmask0[b]) mac_mem[addr0][8*b +: 8] <= din0[8*b +: 8];
    end
  end

  // Reference model
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] exp0[$], exp1[$], got0[$], got1[$];
  int accc0[$], accc1[$], gotc0[$], gotc1[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  logic          s_csb0, s_web0, s_csb1, s_init_done;
  logic [NW-1:0] s_wmask0;
  logic [AW-1:0] s_addr0, s_addr1;
  logic [DW-1:0] s_din0;
  logic          s_rdy0, s_rdy1, s_rv0, s_rv1;

  task automatic idle_inputs();
    req0_valid = 0; req0_we = 0; req0_wmask = '0;
    req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_addr = '0;
    rsp0_ready = 1; rsp1_ready = 1;
  endtask

  task automatic clear_q();
    exp0.delete(); exp1.delete(); got0.delete(); got1.delete();
    accc0.delete(); accc1.delete(); gotc0.delete(); gotc1.delete();
  endtask

  // Inputs are already set for this cycle; sample, update model, advance.
  task automatic run_cycle();
    #1;
    s_csb0 = csb0; s_web0 = web0; s_wmask0 = wmask0;
    s_addr0 = addr0; s_din0 = din0; s_csb1 = csb1; s_addr1 = addr1;
    s_init_done = init_done;
    s_rdy0 = req0_ready; s_rdy1 = req1_ready;
    s_rv0 = rsp0_valid; s_rv1 = rsp1_valid;
    if (rsp0_valid === 1'b1 && rsp0_ready) begin
      got0.push_back(rsp0_rdata); gotc0.push_back(cyc);
    end
    if (rsp1_valid === 1'b1 && rsp1_ready) begin
      got1.push_back(rsp1_rdata); gotc1.push_back(cyc);
    end
    if (req0_valid && req0_ready === 1'b1) begin
      if (req0_we) begin
        for (int b = 0; b < NW; b++)
          if (req0_wmask[b])
            ref_mem[req0_addr][8*b +: 8] = req0_wdata[8*b +: 8];
      end else begin
        exp0.push_back(ref_mem[req0_addr]); accc0.push_back(cyc);
      end
    end
    if (req1_valid && req1_ready === 1'b1) begin
      exp1.push_back(ref_mem[req1_addr]); accc1.push_back(cyc);
    end
    if (rst) begin
      exp0.delete(); exp1.delete();
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic test_reset();
    logic [49:0] g, e;
    clear_q(); idle_inputs();
    rst = 1; scramble = 1;
    req0_valid = 1; req1_valid = 1;
    run_cycle();
    scramble = 0;
    run_cycle(); run_cycle();
    for (int k = 0; k < 2; k++) begin
      if (k == 1) rst = 0;
      run_cycle();
      checks++;
      if ({s_csb0, s_web0, s_csb1, s_wmask0, s_addr0, s_din0, s_addr1}
          !== {3'b111, 4'h0, 8'h0, 32'h0, 8'h0}) begin
        failures++;
        $display("FAIL reset_pins k=%0d csb0=%b web0=%b csb1=%b mask=%h a0=%h d0=%h a1=%h exp idle",
                 k, s_csb0, s_web0, s_csb1, s_wmask0, s_addr0, s_din0, s_addr1);
      end
      checks++;
      if ({s_rdy0, s_rdy1, s_rv0, s_rv1, s_init_done} !== 5'b0) begin
        failures++;
        $display("FAIL reset_flags k=%0d got=%b exp=00000", k,
                 {s_rdy0, s_rdy1, s_rv0, s_rv1, s_init_done});
      end
    end
    for (int i = 0; i < 256; i++) begin
      run_cycle();
      g = {s_csb0, s_web0, s_wmask0, s_din0, s_addr0,
           s_csb1, s_init_done, s_rdy0, s_rdy1};
      e = {1'b0, 1'b0, 4'hF, 32'h0, 8'(i), 1'b1, 1'b0, 1'b0, 1'b0};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL init_cycle i=%0d got=%h exp=%h", i + 1, g, e);
      end
    end
    idle_inputs();
    run_cycle();
    checks++;
    if ({s_init_done, s_rdy0, s_rdy1} !== 3'b111) begin
      failures++;
      $display("FAIL init_done_257 got=%b exp=111",
               {s_init_done, s_rdy0, s_rdy1});
    end
    req0_valid = 1; req0_addr = 8'h00; req1_valid = 1; req1_addr = 8'hFF;
    run_cycle();
    req0_addr = 8'hFF; req1_addr = 8'h00;
    run_cycle();
    idle_inputs();
    repeat (4) run_cycle();
    checks++;
    if (got0.size() != 2 || got1.size() != 2) begin
      failures++;
      $display("FAIL zero_read_count got=%0d/%0d exp=2/2",
               got0.size(), got1.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (got0[k] !== 32'h0 || got1[k] !== 32'h0) begin
          failures++;
          $display("FAIL zero_read k=%0d got=%h/%h exp=0", k, got0[k], got1[k]);
        end
      end
    end
  endtask

  task automatic test_masked_write();
    clear_q(); idle_inputs();
    req0_valid = 1; req0_we = 1; req0_wmask = 4'b0101;
    req0_addr = 8'h10; req0_wdata = 32'hDEADBEEF;
    run_cycle();
    checks++;
    if ({s_csb0, s_web0, s_wmask0, s_addr0, s_din0}
        !== {1'b0, 1'b0, 4'b0101, 8'h10, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL write_pins got=%b%b %h %h %h exp=00 5 10 deadbeef",
               s_csb0, s_web0, s_wmask0, s_addr0, s_din0);
    end
    req0_we = 0;
    run_cycle();
    checks++;
    if ({s_csb0, s_web0, s_addr0} !== {1'b0, 1'b1, 8'h10}) begin
      failures++;
      $display("FAIL read_pins got=%b%b %h exp=01 10", s_csb0, s_web0, s_addr0);
    end
    idle_inputs();
    repeat (4) run_cycle();
    checks++;
    if (got0.size() != 1) begin
      failures++;
      $display("FAIL masked_count got=%0d exp=1", got0.size());
    end else begin
      checks++;
      if (got0[0] !== 32'h00AD00EF) begin
        failures++;
        $display("FAIL masked_data got=%h exp=00ad00ef", got0[0]);
      end
      checks++;
      if (gotc0[0] - accc0[0] != 2) begin
        failures++;
        $display("FAIL read_latency got=%0d exp=2", gotc0[0] - accc0[0]);
      end
    end
  endtask

  task automatic test_hazard();
    int hc;
    clear_q(); idle_inputs();
    req0_valid = 1; req0_we = 1; req0_wmask = 4'hF;
    req0_addr = 8'h20; req0_wdata = 32'h12345678;
    req1_valid = 1; req1_addr = 8'h20;
    hc = cyc;
    run_cycle();
    checks++;
    if ({s_rdy0, s_rdy1} !== 2'b10) begin
      failures++;
      $display("FAIL hazard_stall got=%b exp=10", {s_rdy0, s_rdy1});
    end
    req0_valid = 0;
    run_cycle();
    checks++;
    if (s_rdy1 !== 1'b1) begin
      failures++;
      $display("FAIL hazard_release got=%b exp=1", s_rdy1);
    end
    req0_valid = 1; req0_addr = 8'h21; req1_addr = 8'h22;
    run_cycle();
    checks++;
    if (s_rdy1 !== 1'b1) begin
      failures++;
      $display("FAIL no_false_stall got=%b exp=1", s_rdy1);
    end
    idle_inputs();
    repeat (4) run_cycle();
    checks++;
    if (got1.size() != 2) begin
      failures++;
      $display("FAIL hazard_count got=%0d exp=2", got1.size());
    end else begin
      checks++;
      if (got1[0] !== 32'h12345678 || accc1[0] != hc + 1) begin
        failures++;
        $display("FAIL hazard_data got=%h@%0d exp=12345678@%0d",
                 got1[0], accc1[0], hc + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_q(); idle_inputs();
    for (int a = 1; a <= 8; a++) begin
      req0_valid = 1; req0_we = 1;
      req0_wmask = 4'($urandom_range(1, 15));
      req0_addr = 8'(a); req0_wdata = $urandom;
      run_cycle();
    end
    req0_we = 0; req1_valid = 1;
    for (int a = 1; a <= 8; a++) begin
      req0_addr = 8'(a); req1_addr = 8'(a);
      run_cycle();
      checks++;
      if ({s_rdy0, s_rdy1} !== 2'b11) begin
        failures++;
        $display("FAIL b2b_ready a=%0d got=%b exp=11", a, {s_rdy0, s_rdy1});
      end
    end
    idle_inputs();
    repeat (4) run_cycle();
    checks++;
    if (got0.size() != 8 || got1.size() != 8 ||
        exp0.size() != 8 || exp1.size() != 8) begin
      failures++;
      $display("FAIL b2b_count got=%0d/%0d exp=8/8", got0.size(), got1.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (got0[k] !== exp0[k] || gotc0[k] != accc0[k] + 2) begin
          failures++;
          $display("FAIL b2b_p0 k=%0d got=%h@%0d exp=%h@%0d",
                   k, got0[k], gotc0[k], exp0[k], accc0[k] + 2);
        end
        checks++;
        if (got1[k] !== exp1[k] || gotc1[k] != accc1[k] + 2) begin
          failures++;
          $display("FAIL b2b_p1 k=%0d got=%h@%0d exp=%h@%0d",
                   k, got1[k], gotc1[k], exp1[k], accc1[k] + 2);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    clear_q(); idle_inputs();
    rsp0_ready = 0; req0_valid = 1;
    for (int k = 0; k < 6; k++) begin
      req0_addr = 8'($urandom_range(1, 8));
      run_cycle();
    end
    checks++;
    if (accc0.size() != RD || s_rdy0 !== 1'b0 || s_rv0 !== 1'b1) begin
      failures++;
      $display("FAIL bp_full got=%0d rdy=%b v=%b exp=%0d 0 1",
               accc0.size(), s_rdy0, s_rv0, RD);
    end
    rsp0_ready = 1;
    req0_addr = 8'($urandom_range(1, 8));
    run_cycle();
    checks++;
    if ({s_rv0, s_rdy0} !== 2'b11) begin
      failures++;
      $display("FAIL bp_pop_ready got=%b exp=11", {s_rv0, s_rdy0});
    end
    idle_inputs();
    repeat (6) run_cycle();
    checks++;
    if (got0.size() != RD + 1 || exp0.size() != RD + 1) begin
      failures++;
      $display("FAIL bp_count got=%0d exp=%0d", got0.size(), RD + 1);
    end else begin
      for (int k = 0; k <= RD; k++) begin
        checks++;
        if (got0[k] !== exp0[k]) begin
          failures++;
          $display("FAIL bp_data k=%0d got=%h exp=%h", k, got0[k], exp0[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    clear_q(); idle_inputs();
    for (int k = 0; k < 400; k++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req0_we    = 1'($urandom_range(0, 1));
      req0_wmask = 4'($urandom);
      req0_addr  = 8'($urandom_range(0, 15));
      req0_wdata = $urandom;
      req1_valid = 1'($urandom_range(0, 1));
      req1_addr  = 8'($urandom_range(0, 15));
      rsp0_ready = ($urandom_range(0, 9) < 7);
      rsp1_ready = ($urandom_range(0, 9) < 7);
      run_cycle();
      if (req0_valid && req0_we && s_rdy0 === 1'b1 &&
          req0_addr == req1_addr) begin
        checks++;
        if (s_rdy1 !== 1'b0) begin
          failures++;
          $display("FAIL rand_hazard k=%0d got=%b exp=0", k, s_rdy1);
        end
      end
    end
    idle_inputs();
    repeat (10) run_cycle();
    checks++;
    if (got0.size() != exp0.size() || got1.size() != exp1.size()) begin
      failures++;
      $display("FAIL rand_count got=%0d/%0d exp=%0d/%0d",
               got0.size(), got1.size(), exp0.size(), exp1.size());
    end else begin
      foreach (got0[k]) begin
        checks++;
        if (got0[k] !== exp0[k]) begin
          failures++;
          $display("FAIL rand_p0 k=%0d got=%h exp=%h", k, got0[k], exp0[k]);
        end
      end
      foreach (got1[k]) begin
        checks++;
        if (got1[k] !== exp1[k]) begin
          failures++;
          $display("FAIL rand_p1 k=%0d got=%h exp=%h", k, got1[k], exp1[k]);
        end
      end
    end
  endtask

  task automatic test_reset_midop();
    int  done_at;
    bit  seen_rv;
    logic first_done;
    clear_q(); idle_inputs();
    req0_valid = 1; req0_we = 1; req0_wmask = 4'hF;
    req0_addr = 8'h30; req0_wdata = $urandom | 32'h1;
    run_cycle();
    req0_addr = 8'h31; req0_wdata = $urandom | 32'h1;
    run_cycle();
    req0_we = 0; req0_addr = 8'h30;
    run_cycle();
    req0_addr = 8'h31; req1_valid = 1; req1_addr = 8'h30; rst = 1;
    run_cycle();
    rst = 0; idle_inputs();
    done_at = -1; seen_rv = 0; first_done = 1'bx;
    for (int k = 0; k < 400 && done_at < 0; k++) begin
      run_cycle();
      if (k == 0) first_done = s_init_done;
      if (s_rv0 || s_rv1) seen_rv = 1;
      if (s_init_done === 1'b1) done_at = k;
    end
    checks++;
    if (first_done !== 1'b0) begin
      failures++;
      $display("FAIL midrst_drop got=%b exp=0", first_done);
    end
    checks++;
    if (done_at != 257) begin
      failures++;
      $display("FAIL midrst_init_len got=%0d exp=257", done_at);
    end
    checks++;
    if (seen_rv || got0.size() != 0 || got1.size() != 0) begin
      failures++;
      $display("FAIL midrst_stale got=%0d/%0d exp=0/0",
               got0.size(), got1.size());
    end
    clear_q();
    req0_valid = 1; req0_addr = 8'h30; req1_valid = 1; req1_addr = 8'h31;
    run_cycle();
    req0_addr = 8'h31; req1_addr = 8'h30;
    run_cycle();
    idle_inputs();
    repeat (4) run_cycle();
    checks++;
    if (got0.size() != 2 || got1.size() != 2) begin
      failures++;
      $display("FAIL midrst_read_count got=%0d/%0d exp=2/2",
               got0.size(), got1.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (got0[k] !== 32'h0 || got1[k] !== 32'h0) begin
          failures++;
          $display("FAIL midrst_zero k=%0d got=%h/%h exp=0",
                   k, got0[k], got1[k]);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1;
    @(posedge clk); #1;
    test_reset();
    test_masked_write();
    test_hazard();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
